memory_writeback_queue: RTL and testbench

MEMORY_WRITEBACK_QUEUE -- requirements
Module: memory_writeback_queue

---
 rtl/memory_writeback_queue.sv | 120 ++++++++++++
 tb/tb_memory_writeback_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_writeback_queue.sv
// MEM->WB writeback queue: a small FIFO of register-file write entries between
// the memory stage and write-back, with flush, register-0 write suppression
// and combinational selection of the write-back data at the head.
module memory_writeback_queue #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DEPTH          = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      me_valid,
   output logic                      me_ready,
   input  logic                      me_reg_write,
   input  logic                      me_mem_to_reg,
   input  logic [DATA_WIDTH-1:0]     me_mem_read_data,
   input  logic [DATA_WIDTH-1:0]     me_alu_result,
   input  logic [REG_ADDR_WIDTH-1:0] me_rt_rd,
   input  logic                      flush,
   input  logic                      wb_ready,
   output logic                      wb_valid,
   output logic                      wb_reg_write,
   output logic [DATA_WIDTH-1:0]     wb_write_data,
   output logic [REG_ADDR_WIDTH-1:0] wb_rt_rd,
   output logic [$clog2(DEPTH):0]    occupancy
);

   // A single-entry queue still needs a 1-bit pointer; it simply stays at 0.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic                      reg_write;
      logic                      mem_to_reg;
      logic [DATA_WIDTH-1:0]     mem_read_data;
      logic [DATA_WIDTH-1:0]     alu_result;
      logic [REG_ADDR_WIDTH-1:0] rt_rd;
   } entry_t;

   entry_t               r_mem [DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]     r_count;

   logic                 w_push;
   logic                 w_pop;
   logic [PTR_W-1:0]     w_wr_ptr_nxt;
   logic [PTR_W-1:0]     w_rd_ptr_nxt;
   entry_t               w_head;
   entry_t               w_in;

   // Full queue never accepts, even if the head is leaving this cycle.
   assign me_ready  = (r_count < FULL_CNT);
   assign wb_valid  = (r_count != '0);
   assign occupancy = r_count;

   // Flush cancels both handshakes; reset is handled inside the registers.
   assign w_push = me_valid & me_ready & ~flush;
   assign w_pop  = wb_valid & wb_ready & ~flush;

   // Explicit wrap keeps pointers modulo DEPTH for every legal depth.
   assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

   assign w_head = r_mem[r_rd_ptr];
   assign w_in   = '{reg_write:     me_reg_write,
                     mem_to_reg:    me_mem_to_reg,
                     mem_read_data: me_mem_read_data,
                     alu_result:    me_alu_result,
                     rt_rd:         me_rt_rd};

   // Pointer and occupancy bookkeeping; reset beats flush beats push/pop.
   always_ff @(posedge clock) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
         if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage, written at the tail on an accepted push.
   always_ff @(posedge clock) begin
      // NOTE: the storage is cleared on reset because stale entry fields must
      // read as zero; a plain RAM without reset would not meet that.
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= w_in;
      end
   end

   // Head decode: select write-back data, suppress writes to register 0.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      wb_write_data = '0;
      wb_rt_rd      = '0;
      wb_reg_write  = 1'b0;
      if (wb_valid) begin
         wb_write_data = w_head.mem_to_reg ? w_head.mem_read_data : w_head.alu_result;
         wb_rt_rd      = w_head.rt_rd;
         wb_reg_write  = w_head.reg_write & (w_head.rt_rd != '0);
      end
   end

endmodule

// File: tb/tb_memory_writeback_queue.sv
// Directed bench for memory_writeback_queue (DEPTH=2): reset values, latency,
// full back-pressure, register-0 suppression, wrap, flush and mid-run reset.
module tb_memory_writeback_queue;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          me_valid = 1'b0;
   logic          me_ready;
   logic          me_reg_write = 1'b0;
   logic          me_mem_to_reg = 1'b0;
   logic [DW-1:0] me_mem_read_data = '0;
   logic [DW-1:0] me_alu_result = '0;
   logic [AW-1:0] me_rt_rd = '0;
   logic          flush = 1'b0;
   logic          wb_ready = 1'b0;
   logic          wb_valid;
   logic          wb_reg_write;
   logic [DW-1:0] wb_write_data;
   logic [AW-1:0] wb_rt_rd;
   logic [$clog2(DEPTH):0] occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   memory_writeback_queue #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .me_valid(me_valid), .me_ready(me_ready),
      .me_reg_write(me_reg_write), .me_mem_to_reg(me_mem_to_reg),
      .me_mem_read_data(me_mem_read_data), .me_alu_result(me_alu_result),
      .me_rt_rd(me_rt_rd), .flush(flush), .wb_ready(wb_ready),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_write_data(wb_write_data), .wb_rt_rd(wb_rt_rd),
      .occupancy(occupancy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic rw, input logic m2r, input logic [DW-1:0] mem,
                        input logic [DW-1:0] alu, input logic [AW-1:0] rd);
      me_valid         = 1'b1;
      me_reg_write     = rw;
      me_mem_to_reg    = m2r;
      me_mem_read_data = mem;
      me_alu_result    = alu;
      me_rt_rd         = rd;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_wb_valid"},  wb_valid, 0);
      check({pfx, "_wb_rw"},     wb_reg_write, 0);
      check({pfx, "_wb_data"},   wb_write_data, 0);
      check({pfx, "_wb_rd"},     wb_rt_rd, 0);
      check({pfx, "_occ"},       occupancy, 0);
      check({pfx, "_me_ready"},  me_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      tick(); tick();
      reset = 1'b1;
      check_reset_outputs("rst");

      // Scenario 1: single push, one-cycle latency, popped next cycle
      wb_ready = 1'b1;
      drive(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
      tick();
      me_valid = 1'b0;
      check("s1_valid", wb_valid, 1);
      check("s1_data",  wb_write_data, 32'h1234);
      check("s1_rd",    wb_rt_rd, 5);
      check("s1_rw",    wb_reg_write, 1);
      check("s1_occ",   occupancy, 1);
      tick();
      check("s1_valid_after_pop", wb_valid, 0);
      check("s1_data_zero",       wb_write_data, 0);
      check("s1_occ_after_pop",   occupancy, 0);

      // Scenario 2: fill, refuse C while full, drain in order, accept C
      wb_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h0, 32'h11, 5'd1);
      tick();
      drive(1'b1, 1'b0, 32'h0, 32'h22, 5'd2);
      tick();
      check("s2_occ_full",   occupancy, 2);
      check("s2_ready_full", me_ready, 0);
      drive(1'b1, 1'b0, 32'h0, 32'h33, 5'd3);
      tick();
      check("s2_occ_held",  occupancy, 2);
      check("s2_head_A",    wb_rt_rd, 1);
      check("s2_data_A",    wb_write_data, 32'h11);
      wb_ready = 1'b1;
      tick();
      check("s2_occ_pop1",  occupancy, 1);
      check("s2_head_B",    wb_rt_rd, 2);
      check("s2_ready_C",   me_ready, 1);
      tick();
      me_valid = 1'b0;
      check("s2_occ_pushC", occupancy, 1);
      check("s2_head_C",    wb_rt_rd, 3);
      check("s2_data_C",    wb_write_data, 32'h33);
      tick();
      check("s2_drained",   occupancy, 0);

      // Scenario 3: memory data selected, register 0 write suppressed
      wb_ready = 1'b0;
      drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd0);
      tick();
      me_valid = 1'b0;
      check("s3_valid", wb_valid, 1);
      check("s3_data",  wb_write_data, 32'hDEAD_BEEF);
      check("s3_rd",    wb_rt_rd, 0);
      check("s3_rw",    wb_reg_write, 0);
      wb_ready = 1'b1;
      tick();
      check("s3_drained", occupancy, 0);

      // Scenario 4: occupancy 1 with continuous push+pop across pointer wrap
      wb_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h0, 32'h70, 5'd7);
      tick();
      check("s4_occ_start", occupancy, 1);
      wb_ready = 1'b1;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h100 + 32'(i), AW'(8 + i));
         tick();
         check($sformatf("s4_occ_%0d", i),  occupancy, 1);
         check($sformatf("s4_rd_%0d", i),   wb_rt_rd, 64'(8 + i));
         check($sformatf("s4_data_%0d", i), wb_write_data, 64'(32'h100 + 32'(i)));
         check($sformatf("s4_rw_%0d", i),   wb_reg_write, 1);
      end
      me_valid = 1'b0;
      tick();
      check("s4_drained", occupancy, 0);

      // Scenario 5: flush with a push pending, at occupancy 2 and at 1
      wb_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h0, 32'h90, 5'd9);
      tick();
      drive(1'b1, 1'b0, 32'h0, 32'hA0, 5'd10);
      tick();
      check("s5_occ_full", occupancy, 2);
      flush = 1'b1;
      drive(1'b1, 1'b0, 32'h0, 32'hB0, 5'd11);
      tick();
      flush = 1'b0;
      me_valid = 1'b0;
      check("s5_occ_flushed",   occupancy, 0);
      check("s5_valid_flushed", wb_valid, 0);
      check("s5_ready_flushed", me_ready, 1);
      tick();
      check("s5_no_ghost", wb_valid, 0);
      drive(1'b1, 1'b0, 32'h0, 32'hC0, 5'd12);
      tick();
      check("s5_occ_one", occupancy, 1);
      flush = 1'b1;
      wb_ready = 1'b1;
      drive(1'b1, 1'b0, 32'h0, 32'hD0, 5'd13);
      tick();
      flush = 1'b0;
      me_valid = 1'b0;
      wb_ready = 1'b0;
      check("s5_occ_flush1", occupancy, 0);
      tick();
      check("s5_no_ghost1", wb_valid, 0);
      drive(1'b1, 1'b0, 32'h0, 32'hE0, 5'd14);
      tick();
      me_valid = 1'b0;
      check("s5_post_rd",  wb_rt_rd, 14);
      check("s5_post_occ", occupancy, 1);
      wb_ready = 1'b1;
      tick();
      check("s5_drained", occupancy, 0);

      // Scenario 6: reset mid-run wins over push and pop
      wb_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h0, 32'hF0, 5'd15);
      tick();
      drive(1'b1, 1'b0, 32'h0, 32'hF1, 5'd16);
      tick();
      check("s6_occ_full", occupancy, 2);
      reset = 1'b0;
      wb_ready = 1'b1;
      drive(1'b1, 1'b0, 32'h0, 32'hF2, 5'd17);
      tick();
      reset = 1'b1;
      me_valid = 1'b0;
      check_reset_outputs("s6");
      drive(1'b1, 1'b0, 32'h0, 32'h180, 5'd18);
      tick();
      me_valid = 1'b0;
      check("s6_post_valid", wb_valid, 1);
      check("s6_post_rd",    wb_rt_rd, 18);
      check("s6_post_data",  wb_write_data, 32'h180);
      check("s6_post_occ",   occupancy, 1);
      tick();
      check("s6_drained", occupancy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
